// File: rtl/cpu6_pkg.sv
// cpu6_pkg: shared widths, opcode and FSM state encodings, and instruction
// field helpers for the cpu6 control unit and its register file.
package cpu6_pkg;

  localparam int unsigned DW   = 6;   // datapath / ALU operand width
  localparam int unsigned AW   = 6;   // instruction address width
  localparam int unsigned IW   = 12;  // instruction width
  localparam int unsigned NREG = 4;   // architectural registers
  localparam int unsigned RW   = 2;   // register index width
  localparam int unsigned FW   = 3;   // {CF,SF,ZF}
  localparam int unsigned SW   = 3;   // FSM state width

  // Instruction field positions
  localparam int unsigned OPC_HI = 11;
  localparam int unsigned OPC_LO = 9;
  localparam int unsigned RD_HI  = 8;
  localparam int unsigned RD_LO  = 7;
  localparam int unsigned RS_HI  = 5;
  localparam int unsigned RS_LO  = 4;
  localparam int unsigned IMM_HI = 5;

  localparam logic [2:0] OPC_NOP  = 3'b000;
  localparam logic [2:0] OPC_XAO  = 3'b001;
  localparam logic [2:0] OPC_SHR  = 3'b010;
  localparam logic [2:0] OPC_LDI  = 3'b011;
  localparam logic [2:0] OPC_JZ   = 3'b100;
  localparam logic [2:0] OPC_HALT = 3'b101;

  localparam logic [SW-1:0] ST_IDLE   = 3'd0;
  localparam logic [SW-1:0] ST_FETCH  = 3'd1;
  localparam logic [SW-1:0] ST_DECODE = 3'd2;
  localparam logic [SW-1:0] ST_EXEC   = 3'd3;
  localparam logic [SW-1:0] ST_WB     = 3'd4;
  localparam logic [SW-1:0] ST_HALT   = 3'd5;

  function automatic logic [2:0] opc_of(input logic [IW-1:0] ins);
    return ins[OPC_HI:OPC_LO];
  endfunction

  function automatic logic [RW-1:0] rd_of(input logic [IW-1:0] ins);
    return ins[RD_HI:RD_LO];
  endfunction

  function automatic logic [RW-1:0] rs_of(input logic [IW-1:0] ins);
    return ins[RS_HI:RS_LO];
  endfunction

  function automatic logic [DW-1:0] imm_of(input logic [IW-1:0] ins);
    return ins[IMM_HI:0];
  endfunction

endpackage

// File: rtl/cpu6_regfile.sv
// cpu6_regfile: NREG x DW register file, two combinational read ports and one
// synchronous write port, synchronous active-high reset to zero.
//  clk, rst            clock / sync reset
//  we_i, waddr_i, wdata_i   write port
//  raddr_a_i, raddr_b_i     read addresses
//  rdata_a_c, rdata_b_c     combinational read data
module cpu6_regfile
  import cpu6_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic [RW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [RW-1:0] raddr_a_i,
  input  logic [RW-1:0] raddr_b_i,
  output logic [DW-1:0] rdata_a_c,
  output logic [DW-1:0] rdata_b_c
);

  logic [DW-1:0] regs_q [NREG];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NREG); i++) regs_q[i] <= '0;
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_c = regs_q[raddr_a_i];
  assign rdata_b_c = regs_q[raddr_b_i];

endmodule

// File: rtl/cpu6_control_unit.sv
// cpu6_control_unit: multi-cycle fetch/decode/execute controller driving an
// external combinational 6-bit ALU.
//  clk, rst, run                       clock, sync reset, run level
//  imem_req/addr/ack/data              instruction fetch handshake
//  alu_a, alu_b, alu_op                registered ALU operands / op select
//  alu_r, alu_cf, alu_sf, alu_zf       ALU result and flags
//  flags                               latched {CF,SF,ZF}
//  halted, illegal                     HALT state / undefined-opcode pulse
module cpu6_control_unit
  import cpu6_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [IW-1:0] imem_data,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic          alu_op,
  input  logic [DW-1:0] alu_r,
  input  logic          alu_cf,
  input  logic          alu_sf,
  input  logic          alu_zf,
  output logic [FW-1:0] flags,
  output logic          halted,
  output logic          illegal
);

  logic [SW-1:0] state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [IW-1:0] ir_q, ir_d;
  logic [FW-1:0] flags_q, flags_d;
  logic [DW-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic          alu_op_q, alu_op_d;
  logic          req_q, req_d;
  logic          halted_q, halted_d;
  logic          illegal_q, illegal_d;

  logic          rf_we;
  logic [DW-1:0] rf_wdata;
  logic [DW-1:0] rf_rd_val, rf_rs_val;

  cpu6_regfile u_regfile (
    .clk       (clk),
    .rst       (rst),
    .we_i      (rf_we),
    .waddr_i   (rd_of(ir_q)),
    .wdata_i   (rf_wdata),
    .raddr_a_i (rd_of(ir_q)),
    .raddr_b_i (rs_of(ir_q)),
    .rdata_a_c (rf_rd_val),
    .rdata_b_c (rf_rs_val)
  );

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      ir_q      <= '0;
      flags_q   <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_op_q  <= 1'b0;
      req_q     <= 1'b0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      flags_q   <= flags_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_op_q  <= alu_op_d;
      req_q     <= req_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state, datapath control and register-file write selection
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    flags_d   = flags_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_op_d  = alu_op_q;
    illegal_d = 1'b0;
    rf_we     = 1'b0;
    rf_wdata  = alu_r;

    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (req_q && imem_ack) begin
          ir_d    = imem_data;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        // Single-cycle instructions retire here; run low parks in IDLE
        state_d = run ? ST_FETCH : ST_IDLE;
        pc_d    = pc_q + AW'(1);
        case (opc_of(ir_q))
          OPC_NOP: ;
          OPC_XAO, OPC_SHR: state_d = ST_EXEC;
          OPC_LDI: begin
            rf_we    = 1'b1;
            rf_wdata = imm_of(ir_q);
          end
          OPC_JZ: begin
            if (flags_q[0]) pc_d = imm_of(ir_q);
          end
          OPC_HALT: begin
            pc_d    = pc_q;
            state_d = ST_HALT;
          end
          default: illegal_d = 1'b1;
        endcase
      end
      ST_EXEC: begin
        alu_a_d  = rf_rd_val;
        alu_b_d  = rf_rs_val;
        alu_op_d = (opc_of(ir_q) == OPC_SHR);
        state_d  = ST_WB;
      end
      ST_WB: begin
        rf_we   = 1'b1;
        flags_d = {alu_cf, alu_sf, alu_zf};
        state_d = run ? ST_FETCH : ST_IDLE;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase

    // Request and halt outputs are registered versions of the next state
    req_d    = (state_d == ST_FETCH);
    halted_d = (state_d == ST_HALT);
  end

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign flags     = flags_q;
  assign halted    = halted_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_cpu6_control_unit.sv
// tb_cpu6_control_unit: bench acting as instruction memory and ALU for the
// cpu6 control unit; an instruction-level model pushes the expected retire
// state per instruction, compared when the next fetch (or HALT) appears.
module tb_cpu6_control_unit;

  logic        clk = 1'b0;
  logic        rst, run, imem_ack;
  logic [11:0] imem_data;
  logic        imem_req;
  logic [5:0]  imem_addr;
  logic [5:0]  alu_a, alu_b, alu_r;
  logic        alu_op, alu_cf, alu_sf, alu_zf;
  logic [2:0]  flags;
  logic        halted, illegal;

  cpu6_control_unit dut (
    .clk(clk), .rst(rst), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_r(alu_r), .alu_cf(alu_cf), .alu_sf(alu_sf), .alu_zf(alu_zf),
    .flags(flags), .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ALU: op0 = XOR, op1 = logical shift right by B[2:0], CF = last bit shifted out
  function automatic logic [8:0] alu_f(input logic [5:0] a, input logic [5:0] b, input logic op);
    logic [6:0] t;
    logic [5:0] r;
    logic       cf;
    if (op) begin
      t  = {a, 1'b0} >> b[2:0];
      r  = t[6:1];
      cf = t[0];
    end else begin
      r  = a ^ b;
      cf = 1'b0;
    end
    return {cf, r[5], (r == 6'd0), r};
  endfunction

  assign {alu_cf, alu_sf, alu_zf, alu_r} = alu_f(alu_a, alu_b, alu_op);

  function automatic logic [11:0] ins(input logic [2:0] opc, input logic [1:0] rd, input logic [5:0] f6);
    return {opc, rd, 1'b0, f6};
  endfunction

  typedef struct {
    logic [5:0] pc;
    logic [2:0] flags;
    logic [5:0] a;
    logic [5:0] b;
    logic       op;
    logic       ill;
    logic       halt;
    int         req_cyc;
    logic       chk_gap;
  } exp_t;

  exp_t sb[$];

  logic [11:0] imem [64];
  logic [5:0]  m_reg [4];
  logic [2:0]  m_flags;
  logic [5:0]  m_pc, m_a, m_b;
  logic        m_op;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_reg[i] = 6'd0;
    m_flags = 3'b000;
    m_pc = 6'd0; m_a = 6'd0; m_b = 6'd0; m_op = 1'b0;
    sb.delete();
  endtask

  // Architectural effect of one instruction; pushes the expected retire state
  task automatic model_exec(input logic [11:0] i, input int ack_cyc, input logic chk_gap);
    exp_t e;
    logic [8:0] res;
    logic [1:0] rd, rs;
    int gap;
    rd = i[8:7];
    rs = i[5:4];
    gap = 1;
    e.ill = 1'b0;
    e.halt = 1'b0;
    case (i[11:9])
      3'b001, 3'b010: begin
        m_a = m_reg[rd];
        m_b = m_reg[rs];
        m_op = i[10];
        res = alu_f(m_a, m_b, m_op);
        m_reg[rd] = res[5:0];
        m_flags = res[8:6];
        m_pc = m_pc + 6'd1;
        gap = 3;
      end
      3'b011: begin m_reg[rd] = i[5:0]; m_pc = m_pc + 6'd1; end
      3'b100: m_pc = m_flags[0] ? i[5:0] : m_pc + 6'd1;
      3'b101: e.halt = 1'b1;
      3'b110, 3'b111: begin e.ill = 1'b1; m_pc = m_pc + 6'd1; end
      default: m_pc = m_pc + 6'd1;
    endcase
    e.pc = m_pc; e.flags = m_flags; e.a = m_a; e.b = m_b; e.op = m_op;
    e.req_cyc = ack_cyc + gap;
    e.chk_gap = chk_gap;
    sb.push_back(e);
  endtask

  // Waits (bounded) for the next fetch or HALT, then retires one scoreboard entry
  task automatic wait_req_pop();
    exp_t e;
    int n = 0;
    while (!imem_req && !halted && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("fetch_or_halt_seen", {31'd0, imem_req | halted}, 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (!e.halt) check("next_addr", 32'(imem_addr), 32'(e.pc));
      check("halted", 32'(halted), 32'(e.halt));
      check("flags", 32'(flags), 32'(e.flags));
      check("alu_a", 32'(alu_a), 32'(e.a));
      check("alu_b", 32'(alu_b), 32'(e.b));
      check("alu_op", 32'(alu_op), 32'(e.op));
      check("illegal", 32'(illegal), 32'(e.ill));
      if (e.chk_gap) check("latency", 32'(cyc), 32'(e.req_cyc));
    end
  endtask

  task automatic step_instr(input int dly, input logic drop_run);
    wait_req_pop();
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      check("req_hold", 32'(imem_req), 32'd1);
      check("addr_hold", 32'(imem_addr), 32'(m_pc));
      check("illegal_clr", 32'(illegal), 32'd0);
    end
    imem_ack = 1'b1;
    imem_data = imem[m_pc];
    @(posedge clk);
    #1;
    imem_ack = 1'b0;
    if (drop_run) run = 1'b0;
    model_exec(imem_data, cyc, !drop_run);
    if (drop_run) begin
      repeat (6) begin
        @(negedge clk);
        check("park_noreq", 32'(imem_req), 32'd0);
      end
      run = 1'b1;
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_req"}, 32'(imem_req), 32'd0);
    check({tag, "_addr"}, 32'(imem_addr), 32'd0);
    check({tag, "_a"}, 32'(alu_a), 32'd0);
    check({tag, "_b"}, 32'(alu_b), 32'd0);
    check({tag, "_op"}, 32'(alu_op), 32'd0);
    check({tag, "_flags"}, 32'(flags), 32'd0);
    check({tag, "_halted"}, 32'(halted), 32'd0);
    check({tag, "_illegal"}, 32'(illegal), 32'd0);
  endtask

  initial begin
    int dly;
    rst = 1'b1; run = 1'b0; imem_ack = 1'b0; imem_data = 12'd0;
    for (int i = 0; i < 64; i++) imem[i] = 12'd0;
    imem[0]  = ins(3'b011, 2'd0, 6'h2A);
    imem[1]  = ins(3'b011, 2'd1, 6'h0F);
    imem[2]  = ins(3'b001, 2'd0, 6'h10);   // XAO r0,r1
    imem[3]  = ins(3'b011, 2'd2, 6'h30);
    imem[4]  = ins(3'b011, 2'd3, 6'h04);
    imem[5]  = ins(3'b010, 2'd2, 6'h30);   // SHR r2,r3
    imem[6]  = ins(3'b011, 2'd3, 6'h02);
    imem[7]  = ins(3'b010, 2'd2, 6'h30);   // SHR r2,r3 -> zero
    imem[8]  = ins(3'b100, 2'd0, 6'h10);   // JZ taken
    imem[16] = ins(3'b001, 2'd0, 6'h20);   // XAO r0,r2 -> nonzero
    imem[17] = ins(3'b100, 2'd0, 6'h20);   // JZ not taken
    imem[18] = ins(3'b111, 2'd1, 6'h11);   // illegal
    imem[19] = ins(3'b110, 2'd2, 6'h22);   // illegal
    imem[20] = ins(3'b000, 2'd0, 6'h00);
    imem[21] = ins(3'b001, 2'd1, 6'h10);   // XAO r1,r1 (rd == rs)
    imem[22] = ins(3'b100, 2'd0, 6'h3F);   // JZ to last address
    imem[63] = ins(3'b000, 2'd0, 6'h00);   // NOP, pc wraps to 0
    model_reset();

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset("reset");
    repeat (3) begin
      @(negedge clk);
      check("idle_noreq", 32'(imem_req), 32'd0);
    end

    run = 1'b1;
    for (int p = 0; p < 3; p++) begin
      dly = (p == 0) ? 0 : ((p == 1) ? 1 : 5);
      for (int i = 0; i < 17; i++) step_instr(dly, (p == 1) && (i == 2));
    end

    // Reset while an ALU instruction is in EXEC
    imem[0] = ins(3'b001, 2'd0, 6'h30);    // XAO r0,r3
    imem[1] = ins(3'b101, 2'd0, 6'h00);    // HALT
    wait_req_pop();
    imem_ack = 1'b1;
    imem_data = imem[0];
    @(posedge clk); #1 imem_ack = 1'b0;    // DECODE
    @(posedge clk); #1 rst = 1'b1;        // EXEC
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_reset("rst_exec");
    model_reset();

    // Reset mid-fetch with a pending ack that must be ignored
    begin
      int n = 0;
      while (!imem_req && n < 10) begin @(negedge clk); n++; end
      check("refetch_req", 32'(imem_req), 32'd1);
    end
    rst = 1'b1; imem_ack = 1'b1; imem_data = imem[0];
    @(posedge clk); #1 rst = 1'b0; run = 1'b0;
    @(negedge clk);
    check_reset("rst_fetch");
    @(negedge clk);
    check("late_ack_req", 32'(imem_req), 32'd0);
    check("late_ack_addr", 32'(imem_addr), 32'd0);
    imem_ack = 1'b0;
    run = 1'b1;

    step_instr(0, 1'b0);   // XAO r0,r3 on freshly reset registers
    step_instr(1, 1'b0);   // HALT
    wait_req_pop();
    repeat (5) begin
      @(negedge clk);
      check("halt_sticky", 32'(halted), 32'd1);
      check("halt_noreq", 32'(imem_req), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
